flash_read_arbiter: RTL and testbench
=====================================

Name: flash_read_arbiter

Overview:
- Shares the single flash read port (16-bit address, 16-bit data, fixed latency) between two requesters: port 0 is the network controller's weight/bias fetch, port 1 is the SPI host readback/debug path.
- Round-robin arbitration, one outstanding read at a time.
- Drives the flash ready strobe and address, and returns captured data to the winning requester with a per-port valid pulse.

Parameters:
- FLASH_LAT, 11: cycles from the flash_ready strobe to valid flash_data. Legal range is 1 to 15.
- ADDR_W, 16: address width.
- DATA_W, 16: data width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset. Synchronous and active-high. Already decided.
- req0  in  1  port 0 read request. Hold high with addr0 stable until gnt0.
- addr0  in  ADDR_W  port 0 read address.
- req1  in  1  port 1 read request. Same rules as port 0.
- addr1  in  ADDR_W  port 1 read address.
- flash_data  in  DATA_W  flash read data, valid exactly FLASH_LAT cycles after the strobe.
- flash_ready  out  1  one-cycle read strobe to flash.
- flash_address  out  ADDR_W  registered address presented to flash.
- gnt0  out  1  one-cycle pulse: port 0 request accepted, address captured.
- gnt1  out  1  one-cycle pulse: port 1 request accepted, address captured.
- rdata  out  DATA_W  returned read data. Holds its last value between reads.
- rvalid0  out  1  one-cycle pulse: rdata belongs to port 0.
- rvalid1  out  1  one-cycle pulse: rdata belongs to port 1.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE; the priority pointer goes to port 0.
  - The latency counter, flash_address and rdata go to 0.
  - All pulse outputs and busy go to 0.
  - Any in-flight read is discarded: no rvalid is ever produced for it.
- IDLE:
  - No request: remain in IDLE.
  - Any request: the winner's address is registered into flash_address, the winner is recorded, and the state goes to ISSUE.
  - Winner selection: if only one port requests, it wins. If both request, the port named by the pointer wins.
- ISSUE (exactly 1 cycle):
  - flash_ready=1 and gnt of the winner=1.
  - The pointer moves to the other port. It changes only on a grant.
  - The counter is cleared; next state is WAIT.
- WAIT:
  - The counter increments each cycle.
  - Data is sampled when the cycle is strobe cycle + FLASH_LAT (counter reaches FLASH_LAT-1 in WAIT). At that cycle flash_data is captured into rdata and the state goes to RETURN.
- RETURN (exactly 1 cycle):
  - rvalid of the winner=1; rdata is valid.
  - Next state is IDLE.
- Timing, with a request seen in IDLE at cycle R:
  - flash_ready and gnt at R+1.
  - Flash data at R+1+FLASH_LAT.
  - rvalid at R+2+FLASH_LAT.
  - Maximum throughput is one read per FLASH_LAT+3 cycles.
- Requests outside IDLE are ignored; they are neither queued nor lost.
  - A request still high when the block returns to IDLE is treated as a new request.
  - Requesters deassert req in the cycle after gnt.
- A request dropped while IDLE, before selection, is simply not served.
- The address is sampled only on the IDLE→ISSUE edge; later changes to addrX have no effect.
- gnt0 and gnt1 are never high together, and neither are rvalid0 and rvalid1.
- flash_ready is high only in ISSUE.
- The counter is ceil(log2(FLASH_LAT+1)) bits and does not wrap within a read.

Test Plan:
1. FLASH_LAT=11. req0=1, addr0=0x0005 seen at cycle 0.
   - flash_ready=1, flash_address=0x0005 and gnt0=1 at cycle 1.
   - Flash model drives 0xABCD at cycle 12; rvalid0=1 and rdata=0xABCD at cycle 13.
   - busy is high for cycles 1–13 and low at cycle 14.
2. req0 and req1 held high continuously from reset, re-raised after each rvalid.
   - Grant order is 0,1,0,1.
   - Each strobe comes 14 cycles after the previous one.
   - Addresses match the owning port.
3. Only req1 asserted repeatedly, addr1=0x0100, 0x0101, 0x0102.
   - Every grant goes to port 1.
   - rdata sequence matches the model; rvalid0 is never asserted.
4. Reset mid-read: req0 granted, rst=1 at cycle 6 for one cycle.
   - All outputs are 0 at cycle 7; no rvalid follows.
   - A new req1 is then served with gnt1 (pointer reset to port 0, so req1 still wins when alone).
5. Request during busy: req1 raised at cycle 4 while port 0's read is in WAIT.
   - No gnt1 until the block returns to IDLE.
   - gnt1 pulses at the cycle after RETURN+1.
   - Port 0's read completes unaffected.
6. Boundary FLASH_LAT=1: single req0 at cycle 0.
   - Strobe at cycle 1, capture at cycle 2, rvalid0 at cycle 3.
   - Simultaneous requests still alternate.

Source files
------------

// File: rtl/flash_read_arbiter.sv
// rtl/flash_read_arbiter.sv - round-robin two-port arbiter for the fixed-latency flash read port
//
// Purpose: shares one flash read port between port 0 (network weight/bias fetch)
// and port 1 (SPI host readback/debug), one outstanding read at a time.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   req0/addr0     port 0 request (held with stable address until gnt0)
//   req1/addr1     port 1 request (held with stable address until gnt1)
//   flash_data     flash read data, valid FLASH_LAT cycles after the strobe
//   flash_ready    one-cycle read strobe to flash
//   flash_address  registered address presented to flash
//   gnt0/gnt1      one-cycle grant pulse to the winning port
//   rdata          captured read data, held between reads
//   rvalid0/1      one-cycle pulse marking rdata as belonging to that port
//   busy           high whenever a read is in progress

module flash_read_arbiter #(
  parameter int FLASH_LAT = 11,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] flash_data,
  output logic              flash_ready,
  output logic [ADDR_W-1:0] flash_address,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              busy
);

  localparam int CNT_W = $clog2(FLASH_LAT + 1);
  // Counter restarts at 0 in the first WAIT cycle, so FLASH_LAT-1 lands on
  // strobe cycle + FLASH_LAT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RETURN
  } state_t;

  state_t           state;
  logic             ptr;     // port that wins when both request
  logic             winner;  // port owning the read in flight
  logic [CNT_W-1:0] cnt;
  logic             pick1;

  // Port 1 wins when it is the only requester, or both request and the pointer names it.
  assign pick1 = req1 & (~req0 | ptr);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      winner        <= 1'b0;
      cnt           <= '0;
      flash_address <= '0;
      rdata         <= '0;
      flash_ready   <= 1'b0;
      gnt0          <= 1'b0;
      gnt1          <= 1'b0;
      rvalid0       <= 1'b0;
      rvalid1       <= 1'b0;
    end else begin
      flash_ready <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            winner        <= pick1;
            flash_address <= pick1 ? addr1 : addr0;
            flash_ready   <= 1'b1;
            gnt0          <= ~pick1;
            gnt1          <= pick1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          ptr   <= ~winner;
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            rdata   <= flash_data;
            rvalid0 <= ~winner;
            rvalid1 <= winner;
            state   <= RETURN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RETURN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb/tb_flash_read_arbiter.sv - randomized self-checking bench for flash_read_arbiter

module tb_flash_read_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req0 [2];
  logic        req1 [2];
  logic [15:0] addr0 [2];
  logic [15:0] addr1 [2];
  logic [15:0] flash_data [2];
  logic        flash_ready [2];
  logic [15:0] flash_address [2];
  logic        gnt0 [2];
  logic        gnt1 [2];
  logic [15:0] rdata [2];
  logic        rvalid0 [2];
  logic        rvalid1 [2];
  logic        busy [2];

  int lat [2] = '{11, 1};

  flash_read_arbiter #(.FLASH_LAT(11), .ADDR_W(16), .DATA_W(16)) dut_lat11 (
    .clk(clk), .rst(rst),
    .req0(req0[0]), .addr0(addr0[0]), .req1(req1[0]), .addr1(addr1[0]),
    .flash_data(flash_data[0]), .flash_ready(flash_ready[0]), .flash_address(flash_address[0]),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]), .rdata(rdata[0]),
    .rvalid0(rvalid0[0]), .rvalid1(rvalid1[0]), .busy(busy[0])
  );

  flash_read_arbiter #(.FLASH_LAT(1), .ADDR_W(16), .DATA_W(16)) dut_lat1 (
    .clk(clk), .rst(rst),
    .req0(req0[1]), .addr0(addr0[1]), .req1(req1[1]), .addr1(addr1[1]),
    .flash_data(flash_data[1]), .flash_ready(flash_ready[1]), .flash_address(flash_address[1]),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]), .rdata(rdata[1]),
    .rvalid0(rvalid0[1]), .rvalid1(rvalid1[1]), .busy(busy[1])
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Flash contents: a fixed scramble of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[6:0], a[15:7]} ^ 16'hA5C3;
  endfunction

  // Reference model: a read accepted at edge e owns the port until edge e+LAT+3.
  int          nf [2];
  int          ge [2];
  bit          ptr [2];
  bit          win [2];
  logic [15:0] gaddr [2];
  logic [15:0] e_rdata [2];
  logic [15:0] e_faddr [2];

  // Flash device model and requesters.
  int          fl_due [2];
  logic [15:0] fl_addr [2];
  bit          pend0 [2];
  bit          pend1 [2];
  logic [15:0] seq1 [2];

  task automatic step(input int k, input int e);
    if (rst) begin
      nf[k]      = e + 1;
      ge[k]      = -1000;
      ptr[k]     = 1'b0;
      e_rdata[k] = '0;
      e_faddr[k] = '0;
    end else begin
      if (e >= nf[k] && (req0[k] || req1[k])) begin
        win[k]     = (req0[k] && req1[k]) ? ptr[k] : req1[k];
        ptr[k]     = !win[k];
        ge[k]      = e;
        nf[k]      = e + lat[k] + 3;
        gaddr[k]   = win[k] ? addr1[k] : addr0[k];
        e_faddr[k] = gaddr[k];
      end
      if (e == ge[k] + 1 + lat[k]) e_rdata[k] = mem_word(gaddr[k]);
    end
  endtask

  function automatic bit want0(input int p);
    if (p == 3) return 1'b1;
    if (p >= 40 && p < 120) return 1'b1;
    if (p >= 200) return ($urandom_range(0, 99) < 30);
    return 1'b0;
  endfunction

  function automatic bit want1(input int p);
    if (p >= 40 && p < 200) return 1'b1;
    if (p >= 200) return ($urandom_range(0, 99) < 30);
    return 1'b0;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      req0[k] = 1'b0; req1[k] = 1'b0;
      addr0[k] = '0; addr1[k] = '0;
      flash_data[k] = '0;
      fl_due[k] = -1; fl_addr[k] = '0;
      pend0[k] = 1'b0; pend1[k] = 1'b0;
      seq1[k] = 16'h0100;
      win[k] = 1'b0; gaddr[k] = '0;
      step(k, 1);
    end

    for (int p = 1; p <= 2400; p++) begin
      @(negedge clk);
      rst = (p < 3) || (p == 60) || (p == 170) || (p >= 200 && $urandom_range(0, 149) == 0);
      for (int k = 0; k < 2; k++) begin
        bit fr, rv, bz;
        fr = (p == ge[k]);
        rv = (p == ge[k] + 1 + lat[k]);
        bz = (ge[k] >= 0) && (p >= ge[k]) && (p <= ge[k] + 1 + lat[k]);
        check($sformatf("lat%0d.flash_ready@%0d", lat[k], p), 32'(flash_ready[k]), 32'(fr));
        check($sformatf("lat%0d.gnt0@%0d", lat[k], p), 32'(gnt0[k]), 32'(fr && !win[k]));
        check($sformatf("lat%0d.gnt1@%0d", lat[k], p), 32'(gnt1[k]), 32'(fr && win[k]));
        check($sformatf("lat%0d.rvalid0@%0d", lat[k], p), 32'(rvalid0[k]), 32'(rv && !win[k]));
        check($sformatf("lat%0d.rvalid1@%0d", lat[k], p), 32'(rvalid1[k]), 32'(rv && win[k]));
        check($sformatf("lat%0d.busy@%0d", lat[k], p), 32'(busy[k]), 32'(bz));
        check($sformatf("lat%0d.flash_address@%0d", lat[k], p), 32'(flash_address[k]), 32'(e_faddr[k]));
        check($sformatf("lat%0d.rdata@%0d", lat[k], p), 32'(rdata[k]), 32'(e_rdata[k]));

        // Flash answers the strobe it actually sees, with garbage on every other cycle.
        if (flash_ready[k] === 1'b1) begin
          fl_due[k]  = p + lat[k];
          fl_addr[k] = flash_address[k];
        end
        flash_data[k] = (p == fl_due[k]) ? mem_word(fl_addr[k]) : 16'($urandom);

        // Requesters hold req and address until their grant, then drop req.
        if (gnt0[k] === 1'b1) begin
          pend0[k] = 1'b0; req0[k] = 1'b0; addr0[k] = 16'($urandom);
        end else if (!pend0[k] && want0(p)) begin
          pend0[k] = 1'b1; req0[k] = 1'b1;
          addr0[k] = (p == 3) ? 16'h0005 : 16'($urandom);
        end
        if (gnt1[k] === 1'b1) begin
          pend1[k] = 1'b0; req1[k] = 1'b0; addr1[k] = 16'($urandom);
        end else if (!pend1[k] && want1(p)) begin
          pend1[k] = 1'b1; req1[k] = 1'b1;
          if (p >= 120 && p < 200) begin
            addr1[k] = seq1[k];
            seq1[k]  = seq1[k] + 16'h0001;
          end else begin
            addr1[k] = 16'($urandom);
          end
        end

        step(k, p + 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
